mult4_seq_ctrl: RTL and testbench

- Sequential 4x4-bit unsigned multiplier controller that time-shares one combinational 2x2-bit multiplier slice.
- Sequences the four partial products a_lo*b_lo, a_lo*b_hi, a_hi*b_lo and a_hi*b_hi through the slice, then shifts and accumulates them into an 8-bit product.
- Sits between the switch inputs and the seven-segment display driver; exposes a start/busy/done handshake.

---
 rtl/mult4_seq_ctrl_pkg.sv | 37 +++
 rtl/mult4_seq_ctrl_if.sv | 33 +++
 rtl/mult4_seq_ctrl_slice.sv | 23 ++
 rtl/mult4_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_mult4_seq_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mult4_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the sequential 4x4 multiplier.
//               Holds the controller state encoding, the operand/slice/product
//               widths and the step-to-shift lookup used by the accumulator.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int OP_W    = 4;   // operand width
    localparam int SLICE_W = 2;   // slice operand width
    localparam int PROD_W  = 8;   // product / accumulator width
    localparam int SH_W    = 3;   // width of a shift amount (max shift is 4)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Step 0 is lo*lo, steps 1 and 2 are the cross terms, step 3 is hi*hi.
    function automatic logic [SH_W-1:0] step_shift(input logic [1:0] step);
        logic [SH_W-1:0] sh;
        case (step)
            2'd0:    sh = 3'd0;
            2'd1:    sh = 3'd2;
            2'd2:    sh = 3'd2;
            default: sh = 3'd4;
        endcase
        return sh;
    endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult4_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_if
// Description : Start/busy/done handshake bundle for mult4_seq_ctrl.
// Signals     : start   - request a multiply (master -> slave)
//               a, b    - 4-bit unsigned operands (master -> slave)
//               busy    - controller is working (slave -> master)
//               done    - one-cycle completion pulse (slave -> master)
//               product - 8-bit result, held until next accepted start
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_if;
    import mult_pkg::*;

    logic              start;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface : mult_if
`default_nettype wire

// File: rtl/mult4_seq_ctrl_slice.sv
`default_nettype none
// ============================================================================
// Module      : mult2x2_slice
// Description : Purely combinational 2-bit x 2-bit -> 4-bit unsigned multiplier.
// Ports       : a_i [1:0] - slice multiplicand
//               b_i [1:0] - slice multiplier
//               p_o [3:0] - a_i * b_i
// Revision    : 1.0 - initial release
// ============================================================================
module mult2x2_slice
    import mult_pkg::*;
(
    input  logic [SLICE_W-1:0]   a_i,
    input  logic [SLICE_W-1:0]   b_i,
    output logic [2*SLICE_W-1:0] p_o
);

    localparam int PW = 2 * SLICE_W;

    assign p_o = PW'(a_i) * PW'(b_i);

endmodule : mult2x2_slice
`default_nettype wire

// File: rtl/mult4_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult4_seq_ctrl
// Description : Sequential 4x4 unsigned multiplier. Feeds the four 2x2 partial
//               products through one shared slice and shift-accumulates them
//               into an 8-bit product.
// Parameters  : PIPE_PP - 1 registers the slice result (plus shift) before the
//                         add, costing one extra FLUSH cycle.
// Ports       : clk     - system clock, rising edge
//               rst_n   - asynchronous active-low reset
//               bus     - mult_if slave: start/a/b in, busy/done/product out
// Revision    : 1.0 - initial release
// ============================================================================
module mult4_seq_ctrl
    import mult_pkg::*;
#(
    parameter int PIPE_PP = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    mult_if.slave  bus
);

    state_t              state_q, state_d;
    logic [1:0]          step_q, step_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   product_q, product_d;

    logic [SLICE_W-1:0]   slice_a;
    logic [SLICE_W-1:0]   slice_b;
    logic [2*SLICE_W-1:0] slice_p;
    logic [PROD_W-1:0]    add_term;

    // step[1] picks the a half, step[0] picks the b half.
    assign slice_a = step_q[1] ? a_q[3:2] : a_q[1:0];
    assign slice_b = step_q[0] ? b_q[3:2] : b_q[1:0];

    mult2x2_slice u_slice (
        .a_i (slice_a),
        .b_i (slice_b),
        .p_o (slice_p)
    );

    generate
        if (PIPE_PP != 0) begin : g_pipe
            logic [2*SLICE_W-1:0] pp_q;
            logic [SH_W-1:0]      pp_sh_q;

            // Cleared on start so the add in CALC step 0 contributes nothing.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pp_q    <= '0;
                    pp_sh_q <= '0;
                end else if (state_q == IDLE && bus.start) begin
                    pp_q    <= '0;
                    pp_sh_q <= '0;
                end else if (state_q == CALC) begin
                    pp_q    <= slice_p;
                    pp_sh_q <= step_shift(step_q);
                end
            end

            assign add_term = PROD_W'(pp_q) << pp_sh_q;
        end else begin : g_direct
            assign add_term = PROD_W'(slice_p) << step_shift(step_q);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    // The product register is loaded on the edge entering DONE, so the value
    // is already valid in the cycle where done is high.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    step_d  = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_q + add_term;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    if (PIPE_PP != 0) begin
                        state_d = FLUSH;
                    end else begin
                        state_d   = DONE;
                        product_d = acc_d;
                    end
                end
            end
            FLUSH: begin
                acc_d     = acc_q + add_term;
                product_d = acc_d;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q == CALC) || (state_q == FLUSH);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule : mult4_seq_ctrl
`default_nettype wire

// File: tb/tb_mult4_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult4_seq_ctrl
// Description : Self-checking bench for mult4_seq_ctrl. One instance per
//               PIPE_PP value; expected products come from plain a*b and the
//               expected latency from the 5/6-cycle rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult4_seq_ctrl;

    logic clk;
    logic rst_n;

    mult_if if0 ();
    mult_if if1 ();

    mult4_seq_ctrl #(.PIPE_PP(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    mult4_seq_ctrl #(.PIPE_PP(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_prod [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input int sel, input logic s, input logic [3:0] a, input logic [3:0] b);
        if (sel == 0) begin
            if0.start = s; if0.a = a; if0.b = b;
        end else begin
            if1.start = s; if1.a = a; if1.b = b;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? if0.busy : if1.busy;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? if0.done : if1.done;
    endfunction

    function automatic logic [7:0] get_prod(input int sel);
        return (sel == 0) ? if0.product : if1.product;
    endfunction

    // Called #1 after a rising edge with the selected DUT idle. Checks busy and
    // done every cycle, product on the done cycle, and that nothing further
    // follows the single done pulse.
    task automatic run_op(input int sel, input logic [3:0] a, input logic [3:0] b, input bit noise);
        int lat;
        logic [7:0] exp;
        lat = 5 + sel;
        exp = 8'(int'(a) * int'(b));
        chk($sformatf("hold%0d", sel), 32'(get_prod(sel)), 32'(exp_prod[sel]));
        drive(sel, 1'b1, a, b);
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            if (noise) drive(sel, 1'b1, 4'd7, 4'd7);
            else       drive(sel, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)));
            chk($sformatf("busy%0d_c%0d", sel, cyc), 32'(get_busy(sel)), 32'(cyc < lat));
            chk($sformatf("done%0d_c%0d", sel, cyc), 32'(get_done(sel)), 32'(cyc == lat));
            if (cyc == lat)
                chk($sformatf("prod%0d_%0dx%0d", sel, a, b), 32'(get_prod(sel)), 32'(exp));
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 4'd0, 4'd0);
        chk($sformatf("done_w%0d", sel), 32'(get_done(sel)), 32'd0);
        chk($sformatf("idle%0d", sel), 32'(get_busy(sel)), 32'd0);
        chk($sformatf("stable%0d", sel), 32'(get_prod(sel)), 32'(exp));
        @(posedge clk); #1;
        chk($sformatf("noq_busy%0d", sel), 32'(get_busy(sel)), 32'd0);
        chk($sformatf("noq_done%0d", sel), 32'(get_done(sel)), 32'd0);
        exp_prod[sel] = exp;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 4'd0, 4'd0);
        drive(1, 1'b0, 4'd0, 4'd0);
        exp_prod[0] = 8'd0;
        exp_prod[1] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_busy%0d", s), 32'(get_busy(s)), 32'd0);
            chk($sformatf("rst_done%0d", s), 32'(get_done(s)), 32'd0);
            chk($sformatf("rst_prod%0d", s), 32'(get_prod(s)), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(0, 4'd3,  4'd2,  1'b0);
        run_op(0, 4'd15, 4'd15, 1'b0);
        run_op(1, 4'd15, 4'd15, 1'b0);
        run_op(0, 4'd10, 4'd13, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold130", 32'(get_prod(0)), 32'd130);
        end
        run_op(0, 4'd0,  4'd9,  1'b0);
        run_op(0, 4'd5,  4'd6,  1'b1);

        // Reset during CALC step 2 of 12*12 (cycle 3 after the start edge)
        drive(0, 1'b1, 4'd12, 4'd12);
        @(posedge clk); #1;
        drive(0, 1'b0, 4'd0, 4'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(get_busy(0)), 32'd1);
        chk("pre_rst_prod", 32'(get_prod(0)), 32'd30);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(get_busy(0)), 32'd0);
        chk("arst_done", 32'(get_done(0)), 32'd0);
        chk("arst_prod0", 32'(get_prod(0)), 32'd0);
        chk("arst_prod1", 32'(get_prod(1)), 32'd0);
        exp_prod[0] = 8'd0;
        exp_prod[1] = 8'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 4'd4, 4'd4, 1'b0);

        // Random operations on both variants
        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(1)), 4'($urandom_range(15)),
                   4'($urandom_range(15)), 1'($urandom_range(1)));
        end

        // Exhaustive sweep for both variants
        for (int s = 0; s < 2; s++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    run_op(s, 4'(ia), 4'(ib), 1'b0);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mult4_seq_ctrl
`default_nettype wire
